// File: rtl/snn_pkg.sv
// Shared spike-encoder definitions: default geometry, window length, FSM state encoding.
package snn_pkg;
  localparam int NUM_SPIKES_DEF = 8;
  localparam int IBITS_DEF      = 3;
  localparam int T              = 1 << IBITS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_e;
endpackage

// File: rtl/spike_encoder_if.sv
// Frame-offer handshake into the spike encoder: valid/ready plus the packed intensity frame.
interface spike_encoder_if
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES = NUM_SPIKES_DEF,
  parameter int IBITS      = IBITS_DEF
);
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_SPIKES-1:0][IBITS-1:0] intensities;

  modport master (output in_valid, output intensities, input in_ready);
  modport slave  (input in_valid, input intensities, output in_ready);
endinterface

// File: rtl/spike_channel.sv
// One encoder lane: latches its intensity on accept and registers its spike bit for the upcoming time step.
// Sticky step coding when SPIKE_STICKY_EN is defined, single-cycle pulse otherwise.
module spike_channel
  import snn_pkg::*;
#(
  parameter int IBITS = IBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IBITS-1:0] din,
  input  logic             run_next,
  input  logic [IBITS-1:0] t_next,
  output logic             spike
);
  localparam logic [IBITS-1:0] T_MAX = '1;

  logic [IBITS-1:0] intensity_q, intensity_d;
  logic [IBITS-1:0] fire_t;
  logic             spike_q, spike_d;

  // Spike is computed against next-cycle time so the register lines up with time_step.
  always_comb begin
    intensity_d = load ? din : intensity_q;
    fire_t      = T_MAX - intensity_d;
    spike_d     = 1'b0;
    if (run_next && (intensity_d != '0)) begin
`ifdef SPIKE_STICKY_EN
      spike_d = (t_next >= fire_t);
`else
      spike_d = (t_next == fire_t);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      intensity_q <= '0;
      spike_q     <= 1'b0;
    end else begin
      intensity_q <= intensity_d;
      spike_q     <= spike_d;
    end
  end

  assign spike = spike_q;
endmodule

// File: rtl/spike_encoder.sv
// Time-to-first-spike encoder: one accepted frame becomes a T-cycle spike window, then a DONE pulse.
// Optional macro SPIKE_STICKY_EN selects step coding instead of single pulses.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES = NUM_SPIKES_DEF,
  parameter int IBITS      = IBITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  spike_encoder_if.slave        in_if,
  output logic [NUM_SPIKES-1:0] spikes_out,
  output logic [IBITS-1:0]      time_step,
  output logic                  frame_active,
  output logic                  frame_done
);
  localparam logic [IBITS-1:0] T_MAX = '1;

  enc_state_e       state_q, state_d;
  logic [IBITS-1:0] time_step_q, time_step_d;
  logic             accept;
  logic             run_next;

  always_comb begin
    state_d     = state_q;
    time_step_d = '0;
    accept      = in_if.in_valid && (state_q == IDLE);
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (time_step_q == T_MAX) state_d = DONE;
        else                      time_step_d = time_step_q + IBITS'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    run_next = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      time_step_q <= '0;
    end else begin
      state_q     <= state_d;
      time_step_q <= time_step_d;
    end
  end

  for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_ch
    spike_channel #(.IBITS(IBITS)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .din      (in_if.intensities[i]),
      .run_next (run_next),
      .t_next   (time_step_d),
      .spike    (spikes_out[i])
    );
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign time_step      = time_step_q;
  assign frame_active   = (state_q == RUN);
  assign frame_done     = (state_q == DONE);
endmodule

// File: tb/tb_spike_encoder.sv
// Spike encoder bench: directed scenarios plus random frames against a fire-time reference model.
module tb_spike_encoder;
  localparam int NS = 8;
  localparam int IB = 3;
  localparam int T  = 8;
`ifdef SPIKE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] spikes_out;
  logic [IB-1:0] time_step;
  logic          frame_active;
  logic          frame_done;
  int            errors = 0;
  int            checks = 0;

  spike_encoder_if #(.NUM_SPIKES(NS), .IBITS(IB)) bus ();

  spike_encoder #(.NUM_SPIKES(NS), .IBITS(IB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .spikes_out   (spikes_out),
    .time_step    (time_step),
    .frame_active (frame_active),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel i fires at (T-1)-intensity; zero intensity never fires.
  function automatic logic [NS-1:0] model_spikes(input logic [NS-1:0][IB-1:0] ints, input int t);
    logic [NS-1:0] r;
    int v;
    int f;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      v = int'(ints[i]);
      f = (T - 1) - v;
      if (v != 0 && (STICKY ? (t >= f) : (t == f))) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic run_frame(input logic [NS-1:0][IB-1:0] ints, input int disturb_t,
                           input int rst_t, input string tag);
    int n;
    int t;
    int dones;
    n = 0;
    @(negedge clk);
    bus.intensities = ints;
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.intensities = 24'($urandom);
    for (int c = 1; c <= T + 2; c++) begin
      if (c <= T) begin
        t = c - 1;
        check({tag, "/spikes"}, 32'(spikes_out), 32'(model_spikes(ints, t)));
        check({tag, "/tstep"}, 32'(time_step), 32'(t));
        check({tag, "/active"}, 32'(frame_active), 32'd1);
        check({tag, "/done_run"}, 32'(frame_done), 32'd0);
        check({tag, "/ready_run"}, 32'(bus.in_ready), 32'd0);
        if (t == disturb_t) begin
          bus.intensities = '1;
          bus.in_valid    = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
        if (t == rst_t) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check({tag, "/rst_ready"}, 32'(bus.in_ready), 32'd1);
          check({tag, "/rst_spikes"}, 32'(spikes_out), 32'd0);
          check({tag, "/rst_tstep"}, 32'(time_step), 32'd0);
          check({tag, "/rst_active"}, 32'(frame_active), 32'd0);
          dones = 0;
          for (int k = 0; k < 12; k++) begin
            if (frame_done) dones++;
            @(negedge clk);
          end
          check({tag, "/rst_no_done"}, 32'(dones), 32'd0);
          return;
        end
      end else if (c == T + 1) begin
        bus.in_valid = 1'b0;
        check({tag, "/done"}, 32'(frame_done), 32'd1);
        check({tag, "/done_active"}, 32'(frame_active), 32'd0);
        check({tag, "/done_spikes"}, 32'(spikes_out), 32'd0);
        check({tag, "/done_tstep"}, 32'(time_step), 32'd0);
        check({tag, "/done_ready"}, 32'(bus.in_ready), 32'd0);
      end else begin
        check({tag, "/idle_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "/idle_done"}, 32'(frame_done), 32'd0);
        check({tag, "/idle_spikes"}, 32'(spikes_out), 32'd0);
      end
      @(negedge clk);
    end
  endtask

  logic [NS-1:0][IB-1:0] ints;
  int first_acc;
  int second_acc;
  int done_c;
  int n;

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b1;
    bus.intensities = '1;
    repeat (2) @(negedge clk);
    check("reset/ready", 32'(bus.in_ready), 32'd1);
    check("reset/spikes", 32'(spikes_out), 32'h00);
    check("reset/tstep", 32'(time_step), 32'd0);
    check("reset/done", 32'(frame_done), 32'd0);
    check("reset/active", 32'(frame_active), 32'd0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    ints    = '0;
    ints[0] = 3'd7;
    ints[1] = 3'd0;
    ints[2] = 3'd3;
    for (int i = 3; i < NS; i++) ints[i] = 3'd1;
    run_frame(ints, -1, -1, "single");
    run_frame(ints, 2, -1, "ignore_new");
    run_frame(24'($urandom), -1, 3, "abort");

    @(negedge clk);
    bus.intensities = 24'($urandom);
    bus.in_valid    = 1'b1;
    first_acc  = -1;
    second_acc = -1;
    done_c     = -1;
    for (int c = 0; c < 12; c++) begin
      if (bus.in_ready) begin
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
      end
      if (frame_done && done_c < 0) done_c = c;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("b2b/first", 32'(first_acc), 32'd0);
    check("b2b/period", 32'(second_acc - first_acc), 32'd10);
    check("b2b/done_lat", 32'(done_c - first_acc), 32'd9);
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b/drain", 32'(bus.in_ready), 32'd1);

    ints    = '0;
    ints[0] = 3'd5;
    run_frame(ints, -1, -1, "ch0_5");

    for (int r = 0; r < 8; r++) run_frame(24'($urandom), -1, -1, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter NUM_SPIKES, default 8, number of spike channels (matches neuron fan-in).
REQ-002 SHALL have parameter IBITS, default 3, bits per input intensity; window length T = 2**IBITS cycles.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  intensities frame offered.
REQ-006 SHALL have port in_ready  output  1  encoder can accept a frame.
REQ-007 SHALL have port intensities  input  NUM_SPIKES x IBITS  per-channel intensity, packed [NUM_SPIKES-1:0][IBITS-1:0].
REQ-008 SHALL have port spikes_out  output  NUM_SPIKES  spike vector driving neuron spikes_in.
REQ-009 SHALL have port time_step  output  IBITS  current time index t within window.
REQ-010 SHALL have port frame_active  output  1  high while in RUN.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of window.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE when t = T-1, DONE->IDLE unconditionally.
REQ-013 SHALL assert in_ready only in IDLE; accept = in_valid & in_ready at a rising edge; intensities latched at accept.
REQ-014 SHALL ignore in_valid and intensities outside IDLE; latched values stay unchanged for the whole window.
REQ-015 SHALL enter RUN the cycle after accept with time_step = 0, incrementing by 1 per cycle to T-1 with no wrap inside RUN.
REQ-016 SHALL define fire time of channel i as f_i = (T-1) - intensity_i; intensity 0 never fires.
REQ-017 SHALL present spikes_out from registers, valid in the same cycle time_step shows the corresponding t.
REQ-018 SHALL hold spikes_out = 0, time_step = 0 and frame_active = 0 in IDLE and DONE.
REQ-019 SHALL assert frame_done only in DONE, exactly 9 cycles after the accept edge for IBITS = 3 (T + 1 in general).
REQ-020 SHALL accept the next frame no earlier than the cycle after DONE, so back-to-back frame period is T + 2 cycles.
REQ-021 SHALL perform all time/intensity comparisons unsigned at IBITS width.

Reset
REQ-022 SHALL on rst force state IDLE, in_ready = 1, spikes_out = 0, time_step = 0, frame_active = 0, frame_done = 0 at the next edge.
REQ-023 SHALL give rst priority over accept and over any in-progress window; a frame aborted mid-RUN produces no frame_done.

Configuration
REQ-024 SHALL support macro SPIKE_STICKY_EN.
REQ-025 SHALL, with SPIKE_STICKY_EN defined, hold spikes_out[i] = 1 for every t >= f_i until RUN ends (step coding).
REQ-026 SHALL, without SPIKE_STICKY_EN, assert spikes_out[i] only at t = f_i (single-cycle pulse).

Structure
REQ-027 SHALL place NUM_SPIKES and IBITS defaults, T, and the FSM state enum typedef in shared package snn_pkg.
REQ-028 SHALL use one sub-module spike_channel, instantiated NUM_SPIKES times; it holds the latched intensity and produces one spike bit from time_step.

Verification
REQ-029 SHALL cover reset: rst high 2 cycles -> in_ready = 1, spikes_out = 8'h00, time_step = 0, frame_done = 0.
REQ-030 SHALL cover a single frame: intensities ch0 = 7, ch1 = 0, ch2 = 3, rest 1, no sticky -> ch0 spikes at t=0, ch2 at t=4, ch3..7 at t=6, ch1 never; frame_done 9 cycles after accept.
REQ-031 SHALL cover in_valid held high for two frames -> second accept in the first IDLE cycle after DONE; accepts are 10 cycles apart.
REQ-032 SHALL cover new intensities all 7 driven at t = 2 -> ignored; spike pattern matches the first frame.
REQ-033 SHALL cover rst at t = 3 -> next cycle IDLE, spikes_out = 0, no frame_done pulse.
REQ-034 SHALL cover ch0 = 5 under SPIKE_STICKY_EN -> spikes_out[0] = 1 for t = 2..7; without the macro, high only at t = 2.
